// File: rtl/bnn_pkg.sv
`default_nettype none
// bnn_pkg: shared types for the BNN binarize/pack stage (threshold entries, FSM states).
// Rev 1.0
package bnn_pkg;

  localparam int BNN_CNT_WIDTH = 8;

  typedef logic [BNN_CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    cnt_t thr;
    logic flip;
  } thr_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } bin_state_e;

  // A zero channel count still forms a one-channel pixel; oversize requests saturate.
  function automatic int clamp_nch(input int raw, input int max_ch);
    if (raw == 0) begin
      return 1;
    end else if (raw > max_ch) begin
      return max_ch;
    end else begin
      return raw;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_thr_table.sv
`default_nettype none
// bnn_thr_table: per-channel threshold register file, one sync write port, one comb read port.
// Rev 1.0 -- flip storage present only when BNN_BINARIZE_FLIP_EN is defined.
module bnn_thr_table
  import bnn_pkg::*;
#(
  parameter int MAX_CH = 256,
  parameter int CH_W   = $clog2(MAX_CH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  cnt_t            wthr,
  input  logic            wflip,
  input  logic [CH_W-1:0] raddr,
  output thr_entry_t      rd_entry
);

  // Contents are deliberately left unreset; software loads them before use.
  cnt_t thr_mem [MAX_CH];

`ifdef BNN_BINARIZE_FLIP_EN
  logic [MAX_CH-1:0] flip_mem;

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < MAX_CH)) begin
      thr_mem[waddr]  <= wthr;
      flip_mem[waddr] <= wflip;
    end
  end

  always_comb begin
    rd_entry.thr  = thr_mem[raddr];
    rd_entry.flip = flip_mem[raddr];
  end
`else
  logic unused_flip;
  assign unused_flip = wflip;

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < MAX_CH)) begin
      thr_mem[waddr] <= wthr;
    end
  end

  always_comb begin
    rd_entry.thr  = thr_mem[raddr];
    rd_entry.flip = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/bnn_binarize_pack.sv
`default_nettype none
// bnn_binarize_pack: thresholds per-channel popcounts to bits and packs them into PACK_WIDTH words.
// Rev 1.0 -- optional per-channel output inversion via BNN_BINARIZE_FLIP_EN.
module bnn_binarize_pack
  import bnn_pkg::*;
#(
  parameter int CNT_WIDTH  = BNN_CNT_WIDTH,
  parameter int PACK_WIDTH = 144,
  parameter int MAX_CH     = 256,
  localparam int CH_W      = $clog2(MAX_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_addr_i,
  input  logic [CNT_WIDTH-1:0]  cfg_thr_i,
  input  logic                  cfg_flip_i,
  input  logic [CH_W:0]         cfg_nch_i,
  input  logic                  cnt_valid_i,
  output logic                  cnt_ready_o,
  input  logic [CNT_WIDTH-1:0]  cnt_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PACK_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int PTR_W = $clog2(PACK_WIDTH);

  bin_state_e            state;
  logic [CH_W-1:0]       ch;
  logic [CH_W:0]         nch;
  logic [PTR_W-1:0]      ptr;
  logic [PACK_WIDTH-1:0] pack;

  thr_entry_t            entry;
  logic                  accept;
  logic [CH_W:0]         nch_eff;
  logic                  last_ch;
  logic                  word_done;
  logic                  act_bit;
  logic [PACK_WIDTH-1:0] word_next;

  bnn_thr_table #(
    .MAX_CH (MAX_CH),
    .CH_W   (CH_W)
  ) u_thr_table (
    .clk      (clk_i),
    .we       (cfg_we_i),
    .waddr    (cfg_addr_i),
    .wthr     (cfg_thr_i),
    .wflip    (cfg_flip_i),
    .raddr    (ch),
    .rd_entry (entry)
  );

  assign cnt_ready_o = !out_valid_o || out_ready_i;
  assign accept      = cnt_valid_i && cnt_ready_o;
  assign busy_o      = (state == ACCUM) || out_valid_o;

  // The channel count is only sampled on the first count of a pixel.
  assign nch_eff   = (state == IDLE) ? (CH_W+1)'(clamp_nch(int'(cfg_nch_i), MAX_CH)) : nch;
  assign last_ch   = ({1'b0, ch} == (nch_eff - 1'b1));
  assign word_done = (ptr == PTR_W'(PACK_WIDTH - 1)) || last_ch;
  assign act_bit   = (cnt_data_i >= entry.thr) ^ entry.flip;

  always_comb begin
    word_next      = pack;
    word_next[ptr] = act_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ch          <= '0;
      nch         <= '0;
      ptr         <= '0;
      pack        <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      if (accept) begin
        // A completed word overrides the drain above, giving back-to-back throughput.
        if (word_done) begin
          out_data_o  <= word_next;
          out_last_o  <= last_ch;
          out_valid_o <= 1'b1;
          pack        <= '0;
          ptr         <= '0;
        end else begin
          pack <= word_next;
          ptr  <= ptr + 1'b1;
        end

        ch <= last_ch ? '0 : ch + 1'b1;

        case (state)
          IDLE: begin
            nch   <= nch_eff;
            state <= last_ch ? IDLE : ACCUM;
          end
          ACCUM: begin
            if (last_ch) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
